seq_pattern_gen: RTL and testbench
==================================

# seq_pattern_gen

Programmable serial pattern source that drives `seq_signal` into the sequence-checker stage directly downstream. It holds a configurable pattern of up to PAT_W bits, shifts it out MSB-first, holds each bit for a programmable number of clocks, and repeats it a set number of times or continuously. The reset configuration emits `1110010`, which is the target sequence the checker detects, so the checker can be exercised with no configuration traffic.

## Interface
- `PAT_W`, 16: pattern register width; maximum pattern length.
- `DIV_W`, 8: width of the bit-period divider.
- `sys_clk` input 1: system clock; all logic on the rising edge.
- `sys_rst` input 1: reset, synchronous and active-high.
- `seq_en` input 1: a rising edge starts a run; low aborts a run.
- `cfg_load` input 1: latch the `cfg_*` inputs; honoured only in IDLE.
- `cfg_pattern` input PAT_W: pattern bits; bit [len-1] is sent first.
- `cfg_len` input 5: number of pattern bits to send.
- `cfg_rep` input 8: number of pattern repetitions; 0 means continuous.
- `cfg_div` input DIV_W: bit period minus 1, in clocks.
- `seq_signal` output 1: registered serial bit to the checker.
- `seq_valid` output 1: high on the first clock of each bit.
- `busy` output 1: high while in RUN.
- `done` output 1: one-clock pulse when a finite run completes.

## Operation
- Internal config registers and their reset values:
  - `pat_r` = 16'h0072
  - `len_r` = 7
  - `rep_r` = 1
  - `div_r` = 0
- Output reset values: `seq_signal`=0, `seq_valid`=0, `busy`=0, `done`=0. State resets to IDLE.
- `cfg_load` behaviour:
  - In IDLE, `cfg_load`=1 latches all four config registers at that edge.
  - `cfg_len`=0 is stored as 1. `cfg_len`>PAT_W is stored as PAT_W.
  - `cfg_load` in RUN or FIN is ignored.
- `seq_en` is registered into `en_d` every cycle. start = `seq_en` & ~`en_d`.
- State machine:
  - IDLE -> RUN on start. If `cfg_load` and start occur together, the new config is latched and used for this run.
  - In RUN, `seq_signal` is `pat_r[idx]`. `idx` counts from `len_r`-1 down to 0, and `div_cnt` counts from `div_r` down to 0 within each bit.
  - When `div_cnt`=0 and `idx`>0: `idx` decrements, `div_cnt` reloads, and `seq_valid` pulses.
  - When `div_cnt`=0 and `idx`=0 (end of pattern):
    - If `rep_r`=0: wrap `idx` to `len_r`-1.
    - Else if `rep_cnt`>1: decrement `rep_cnt` and wrap.
    - Else: go to FIN.
  - RUN -> IDLE when `seq_en`=0 (abort). This takes priority over all RUN transitions. `seq_signal`, `seq_valid` and `busy` go to 0 the next cycle, and `done` stays 0.
  - FIN -> IDLE unconditionally after one cycle, with `done`=1, `busy`=0 and `seq_signal`=0 during FIN.
- Restart rules:
  - `seq_en` held high after FIN does not restart; a new rising edge is required.
  - A rising edge that occurs during FIN is lost.
- `sys_rst` asserted in any state, including mid-run, restores all reset values at that edge, including the config registers.

## Timing
- Start latency: when start is sampled at edge E, at E+1 `seq_signal`=`pat_r[len_r-1]`, `seq_valid`=1 and `busy`=1.
- Each bit is held exactly `div_r`+1 clocks. `seq_valid` is high on the first of those clocks only.
- A finite run keeps `busy` high for `len_r`×(`div_r`+1)×`rep_r` clocks. `done` is high in the following clock.
- Wrap-around between repetitions has no gap: the bit after `idx`=0 is `pat_r[len_r-1]` on the next period.
- `seq_signal` is 0 whenever the block is not in RUN.
- Abort latency: `seq_en` sampled low at edge E gives IDLE outputs at E+1.

## Test plan
- Default pattern: reset, then raise `seq_en`.
  - `seq_signal` = 1,1,1,0,0,1,0 on 7 consecutive clocks, with `seq_valid` high on each.
  - `done` pulses at clock 8 and `busy` falls at clock 8.
  - The downstream checker's `led` goes low.
- Divider and repeat: load pattern 16'h000B, `cfg_len`=4, `cfg_div`=2, `cfg_rep`=3, then start.
  - Bits 1,0,1,1 are each held 3 clocks, repeated 3 times.
  - `busy` is high for 36 clocks, then `done` pulses once.
- Continuous and abort: `cfg_rep`=0 with the default pattern, `seq_en` held high for 50 clocks, then dropped.
  - The pattern repeats with no gap.
  - Outputs are 0 one clock after the drop, and `done` never pulses.
- Config guard and clamp:
  - `cfg_load` with 16'hFFFF mid-run: the run continues with the old pattern.
  - `cfg_len`=0 in IDLE: the next run emits 1 bit then `done`.
  - `cfg_len`=20 in IDLE: the next run emits 16 bits.
- Reset mid-run: assert `sys_rst` at bit 4 of a custom-pattern run.
  - All outputs are 0 on the next clock.
  - A subsequent start emits the default 1110010.
- Restart edge: hold `seq_en` high after `done`.
  - There is no second run.
  - Toggling `seq_en` low then high starts a new run with 1-clock latency.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// Programmable serial pattern source: shifts a stored pattern out MSB-first,
// stretching each bit over a programmable period, for a set or unlimited repeat count.
module seq_pattern_gen #(
  parameter int PAT_W = 16,
  parameter int DIV_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             seq_en,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [4:0]       cfg_len,
  input  logic [7:0]       cfg_rep,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             seq_signal,
  output logic             seq_valid,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [5:0]       PAT_W6  = 6'(PAT_W);
  localparam logic [PAT_W-1:0] PAT_RST = {{(PAT_W-7){1'b0}}, 7'b1110010};
  localparam logic [IDX_W-1:0] IDX_ONE = 1;
  localparam logic [DIV_W-1:0] DIV_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  // Length is kept as the index of the first bit sent (len-1), clamped to [1, PAT_W].
  function automatic logic [IDX_W-1:0] clamp_last(input logic [4:0] l);
    if (l == 5'd0)
      return '0;
    else if ({1'b0, l} > PAT_W6)
      return IDX_W'(PAT_W - 1);
    else
      return IDX_W'(l - 5'd1);
  endfunction

  state_t           r_state, w_state;
  logic             r_en_d;
  logic [PAT_W-1:0] r_pat, w_pat;
  logic [IDX_W-1:0] r_last, w_last;
  logic [7:0]       r_rep, w_rep;
  logic [DIV_W-1:0] r_div, w_div;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [DIV_W-1:0] r_div_cnt, w_div_cnt;
  logic [7:0]       r_rep_cnt, w_rep_cnt;
  logic             r_sig, w_sig;
  logic             r_vld, w_vld;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             w_start;
  logic             w_load;

  always_comb begin
    w_start   = seq_en & ~r_en_d;
    w_load    = (r_state == S_IDLE) & cfg_load;
    w_state   = r_state;
    w_pat     = r_pat;
    w_last    = r_last;
    w_rep     = r_rep;
    w_div     = r_div;
    w_idx     = r_idx;
    w_div_cnt = r_div_cnt;
    w_rep_cnt = r_rep_cnt;
    w_vld     = 1'b0;
    w_done    = 1'b0;

    if (w_load) begin
      w_pat  = cfg_pattern;
      w_last = clamp_last(cfg_len);
      w_rep  = cfg_rep;
      w_div  = cfg_div;
    end

    case (r_state)
      S_IDLE: begin
        // A load coinciding with start feeds the new config straight into this run.
        if (w_start) begin
          w_state   = S_RUN;
          w_idx     = w_last;
          w_div_cnt = w_div;
          w_rep_cnt = w_rep;
          w_vld     = 1'b1;
        end
      end
      S_RUN: begin
        if (!seq_en) begin
          w_state = S_IDLE;
        end else if (r_div_cnt != '0) begin
          w_div_cnt = r_div_cnt - DIV_ONE;
        end else if (r_idx != '0) begin
          w_idx     = r_idx - IDX_ONE;
          w_div_cnt = r_div;
          w_vld     = 1'b1;
        end else if ((r_rep == 8'd0) || (r_rep_cnt > 8'd1)) begin
          if (r_rep != 8'd0)
            w_rep_cnt = r_rep_cnt - 8'd1;
          w_idx     = r_last;
          w_div_cnt = r_div;
          w_vld     = 1'b1;
        end else begin
          w_state = S_FIN;
          w_done  = 1'b1;
        end
      end
      S_FIN:   w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    w_busy = (w_state == S_RUN);
    w_sig  = w_busy & w_pat[w_idx];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_en_d    <= 1'b0;
      r_pat     <= PAT_RST;
      r_last    <= IDX_W'(6);
      r_rep     <= 8'd1;
      r_div     <= '0;
      r_idx     <= '0;
      r_div_cnt <= '0;
      r_rep_cnt <= '0;
      r_sig     <= 1'b0;
      r_vld     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_en_d    <= seq_en;
      r_pat     <= w_pat;
      r_last    <= w_last;
      r_rep     <= w_rep;
      r_div     <= w_div;
      r_idx     <= w_idx;
      r_div_cnt <= w_div_cnt;
      r_rep_cnt <= w_rep_cnt;
      r_sig     <= w_sig;
      r_vld     <= w_vld;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  assign seq_signal = r_sig;
  assign seq_valid  = r_vld;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: directed and randomized runs compared cycle by cycle
// against an arithmetic model of the emitted bit stream.
module tb_seq_pattern_gen;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        seq_en;
  logic        cfg_load;
  logic [15:0] cfg_pattern;
  logic [4:0]  cfg_len;
  logic [7:0]  cfg_rep;
  logic [7:0]  cfg_div;
  logic        seq_signal;
  logic        seq_valid;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  seq_pattern_gen #(.PAT_W(16), .DIV_W(8)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .seq_en      (seq_en),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_rep     (cfg_rep),
    .cfg_div     (cfg_div),
    .seq_signal  (seq_signal),
    .seq_valid   (seq_valid),
    .busy        (busy),
    .done        (done)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".sig"},  seq_signal, 0);
    chk({tag, ".vld"},  seq_valid,  0);
    chk({tag, ".busy"}, busy,       0);
    chk({tag, ".done"}, done,       0);
  endtask

  // Bit sent on clock k of a run: pattern position walks len-1..0 once per bit period.
  function automatic logic ref_bit(input logic [15:0] p, input int len, input int div, input int k);
    int pos;
    pos = len - 1 - ((k / (div + 1)) % len);
    return p[pos];
  endfunction

  function automatic int eff_len(input int l);
    if (l == 0) return 1;
    if (l > 16) return 16;
    return l;
  endfunction

  // Called right after the start edge; optionally drives a config load at clock load_at.
  task automatic expect_run(input string tag, input logic [15:0] p, input int len,
                            input int div, input int rep, input int load_at);
    int total;
    total = len * (div + 1) * rep;
    for (int k = 0; k < total; k++) begin
      chk($sformatf("%s.sig[%0d]", tag, k),  seq_signal, ref_bit(p, len, div, k));
      chk($sformatf("%s.vld[%0d]", tag, k),  seq_valid,  ((k % (div + 1)) == 0));
      chk($sformatf("%s.busy[%0d]", tag, k), busy,       1);
      chk($sformatf("%s.done[%0d]", tag, k), done,       0);
      if (k == load_at) begin
        cfg_load    = 1'b1;
        cfg_pattern = 16'hFFFF;
        cfg_len     = 5'd16;
        cfg_div     = 8'd0;
        cfg_rep     = 8'd5;
      end
      step();
      cfg_load = 1'b0;
    end
    chk({tag, ".fin.done"}, done,       1);
    chk({tag, ".fin.busy"}, busy,       0);
    chk({tag, ".fin.sig"},  seq_signal, 0);
    chk({tag, ".fin.vld"},  seq_valid,  0);
    step();
    chk({tag, ".post.done"}, done, 0);
    chk({tag, ".post.busy"}, busy, 0);
  endtask

  task automatic load_cfg(input logic [15:0] p, input logic [4:0] l,
                          input logic [7:0] d, input logic [7:0] r);
    seq_en = 1'b0;
    step();
    cfg_pattern = p;
    cfg_len     = l;
    cfg_div     = d;
    cfg_rep     = r;
    cfg_load    = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  initial begin
    logic [15:0] rp;
    int          rl, rd, rr;

    sys_rst     = 1'b1;
    seq_en      = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_rep     = '0;
    cfg_div     = '0;
    step();
    step();
    chk_idle("reset");
    sys_rst = 1'b0;
    step();

    // Default configuration run, then restart rules
    seq_en = 1'b1;
    step();
    expect_run("dflt", 16'h0072, 7, 0, 1, -1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_idle($sformatf("hold[%0d]", i));
    end
    seq_en = 1'b0;
    step();
    seq_en = 1'b1;
    step();
    expect_run("restart", 16'h0072, 7, 0, 1, -1);

    // Divider and repeat
    load_cfg(16'h000B, 5'd4, 8'd2, 8'd3);
    seq_en = 1'b1;
    step();
    expect_run("divrep", 16'h000B, 4, 2, 3, -1);

    // Load attempted mid-run is ignored, and the old config persists afterwards
    load_cfg(16'h00B5, 5'd8, 8'd1, 8'd2);
    seq_en = 1'b1;
    step();
    expect_run("guard", 16'h00B5, 8, 1, 2, 5);
    seq_en = 1'b0;
    step();
    seq_en = 1'b1;
    step();
    expect_run("guard2", 16'h00B5, 8, 1, 2, -1);

    // Length clamps
    load_cfg(16'hA5C3, 5'd0, 8'd0, 8'd1);
    seq_en = 1'b1;
    step();
    expect_run("len0", 16'hA5C3, 1, 0, 1, -1);
    load_cfg(16'hA5C3, 5'd20, 8'd0, 8'd1);
    seq_en = 1'b1;
    step();
    expect_run("len20", 16'hA5C3, 16, 0, 1, -1);

    // Randomized configs, loaded on the same edge as start
    for (int it = 0; it < 8; it++) begin
      rp = 16'($urandom);
      rl = $urandom_range(0, 20);
      rd = $urandom_range(0, 3);
      rr = $urandom_range(1, 3);
      seq_en = 1'b0;
      step();
      cfg_pattern = rp;
      cfg_len     = 5'(rl);
      cfg_div     = 8'(rd);
      cfg_rep     = 8'(rr);
      cfg_load    = 1'b1;
      seq_en      = 1'b1;
      step();
      cfg_load = 1'b0;
      expect_run($sformatf("rand%0d", it), rp, eff_len(rl), rd, rr, -1);
    end

    // Continuous mode followed by abort
    load_cfg(16'h0072, 5'd7, 8'd0, 8'd0);
    seq_en = 1'b1;
    step();
    for (int k = 0; k < 50; k++) begin
      chk($sformatf("cont.sig[%0d]", k),  seq_signal, ref_bit(16'h0072, 7, 0, k));
      chk($sformatf("cont.vld[%0d]", k),  seq_valid,  1);
      chk($sformatf("cont.busy[%0d]", k), busy,       1);
      chk($sformatf("cont.done[%0d]", k), done,       0);
      if (k == 49) seq_en = 1'b0;
      step();
    end
    chk_idle("abort");
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("abort.done[%0d]", i), done, 0);
    end

    // Reset in the middle of a custom run restores the default config
    load_cfg(16'h3C5A, 5'd8, 8'd0, 8'd1);
    seq_en = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rstrun.sig[%0d]", k), seq_signal, ref_bit(16'h3C5A, 8, 0, k));
      if (k < 4) step();
    end
    sys_rst = 1'b1;
    seq_en  = 1'b0;
    step();
    chk_idle("midrst");
    sys_rst = 1'b0;
    step();
    seq_en = 1'b1;
    step();
    expect_run("postrst", 16'h0072, 7, 0, 1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
